spi_matrix_reader: RTL and testbench

- SPI master that reads a result matrix out of an SPI-slave matrix sender, one 32-bit word per chip-select frame.
- Writes each received word into a local result buffer through a simple write port.
- Sits on the host/test-controller side of the matrix accelerator's SPI link, mirroring the slave-side sender.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first, cs_n deasserted between words so the slave can load its next word.

---
 rtl/spi_matrix_reader_if.sv | 25 ++
 rtl/spi_matrix_reader.sv | 160 ++++++++++++++++
 tb/tb_spi_matrix_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_matrix_reader_if.sv
// Bus bundle between the SPI matrix reader, its SPI slave and the result-buffer write port.
// The master modport is the reader side; the slave modport is everything facing it.
interface spi_matrix_reader_if;
  logic        start;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    input  start, word_count, miso,
    output busy, done, sclk, cs_n, mosi, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, word_count, miso,
    input  busy, done, sclk, cs_n, mosi, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/spi_matrix_reader.sv
// SPI mode-0 master that reads one 32-bit word per chip-select frame from a matrix sender
// and writes each word into a local result buffer.
module spi_matrix_reader #(
  parameter int CLK_DIV   = 4,
  parameter int CS_SETUP  = 8,
  parameter int CS_HOLD   = 2,
  parameter int CS_GAP    = 8,
  parameter int MAX_WORDS = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_matrix_reader_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_GAP    = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

  state_t      state_r;
  logic [15:0] cnt_r;
  logic [15:0] idx_r;
  logic [15:0] tmr_r;
  logic [4:0]  bit_r;
  logic [31:0] shreg_r;
  logic        sclk_r;
  logic        cs_n_r;
  logic        busy_r;
  logic        done_r;
  logic        wr_en_r;
  logic [15:0] wr_addr_r;
  logic [31:0] wr_data_r;
  logic [15:0] cnt_clamp_s;

  // Requested length saturated to the buffer depth
  always_comb begin
    cnt_clamp_s = (bus.word_count > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : bus.word_count;
  end

  // Frame sequencer; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      idx_r     <= 16'd0;
      tmr_r     <= 16'd0;
      bit_r     <= 5'd0;
      shreg_r   <= 32'd0;
      sclk_r    <= 1'b0;
      cs_n_r    <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= 16'd0;
      wr_data_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            cnt_r <= cnt_clamp_s;
            idx_r <= 16'd0;
            if (cnt_clamp_s == 16'd0) begin
              state_r <= ST_FINISH;
            end else begin
              state_r <= ST_SETUP;
              cs_n_r  <= 1'b0;
              busy_r  <= 1'b1;
              tmr_r   <= 16'(CS_SETUP - 1);
            end
          end
        end
        ST_SETUP: begin
          if (tmr_r == 16'd0) begin
            state_r <= ST_SHIFT;
            sclk_r  <= 1'b1;
            shreg_r <= {shreg_r[30:0], bus.miso};
            tmr_r   <= 16'(CLK_DIV - 1);
            bit_r   <= 5'd0;
          end else begin
            tmr_r <= tmr_r - 16'd1;
          end
        end
        // miso is captured on the same clk edge that raises sclk
        ST_SHIFT: begin
          if (tmr_r != 16'd0) begin
            tmr_r <= tmr_r - 16'd1;
          end else if (sclk_r) begin
            sclk_r <= 1'b0;
            tmr_r  <= 16'(CLK_DIV - 1);
          end else if (bit_r == 5'd31) begin
            state_r <= ST_HOLD;
            tmr_r   <= 16'(CS_HOLD - 1);
          end else begin
            bit_r   <= bit_r + 5'd1;
            sclk_r  <= 1'b1;
            shreg_r <= {shreg_r[30:0], bus.miso};
            tmr_r   <= 16'(CLK_DIV - 1);
          end
        end
        ST_HOLD: begin
          if (tmr_r == 16'd0) begin
            state_r   <= ST_WRITE;
            cs_n_r    <= 1'b1;
            wr_en_r   <= 1'b1;
            wr_addr_r <= idx_r;
            wr_data_r <= shreg_r;
          end else begin
            tmr_r <= tmr_r - 16'd1;
          end
        end
        ST_WRITE: begin
          wr_en_r <= 1'b0;
          idx_r   <= idx_r + 16'd1;
          state_r <= ST_GAP;
          tmr_r   <= 16'(CS_GAP - 1);
        end
        ST_GAP: begin
          if (tmr_r != 16'd0) begin
            tmr_r <= tmr_r - 16'd1;
          end else if (idx_r == cnt_r) begin
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_SETUP;
            cs_n_r  <= 1'b0;
            tmr_r   <= 16'(CS_SETUP - 1);
          end
        end
        ST_FINISH: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          sclk_r  <= 1'b0;
          cs_n_r  <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          wr_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sclk    = sclk_r;
  assign bus.cs_n    = cs_n_r;
  assign bus.mosi    = 1'b0;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.wr_en   = wr_en_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;

endmodule

// File: tb/tb_spi_matrix_reader.sv
// Scoreboard bench for spi_matrix_reader: behavioural SPI slaves feed miso, monitors compare
// buffer writes, frame timing and done latency against queued expectations.
module tb_spi_matrix_reader;
  localparam int CLK_DIV    = 4;
  localparam int CS_SETUP   = 8;
  localparam int CS_HOLD    = 2;
  localparam int CS_GAP     = 8;
  localparam int MAX_WORDS  = 100;
  localparam int FRAME_LEN  = CS_SETUP + 64 * CLK_DIV + CS_HOLD;
  localparam int FRAME_LEN2 = CS_SETUP + 64 * 2 + CS_HOLD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_matrix_reader_if ifc ();
  spi_matrix_reader_if ifc2 ();

  spi_matrix_reader #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                      .CS_GAP(CS_GAP), .MAX_WORDS(MAX_WORDS))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  spi_matrix_reader #(.CLK_DIV(2), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                      .CS_GAP(CS_GAP), .MAX_WORDS(MAX_WORDS))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int done_cnt = 0;
  int frame_cnt = 0;
  int last_wr_addr = -1;
  logic [15:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          exp_gap_q[$];

  logic [31:0] slave_mem [0:127];
  int s1_frame = 0;
  int s1_fall = 0;
  bit s1_prev = 1'b0;
  bit s1_low = 1'b0;

  logic [31:0] slave2_word = 32'd0;
  int s2_fall = 0;
  bit s2_prev = 1'b0;
  logic [31:0] exp2_q[$];
  int done2_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave for the main DUT: presents the next bit after each falling sclk
  initial begin
    ifc.miso = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.cs_n) begin
        if (s1_low) s1_frame++;
        s1_low = 1'b0;
        s1_fall = 0;
        s1_prev = 1'b0;
      end else begin
        s1_low = 1'b1;
        if (s1_prev && !ifc.sclk) s1_fall++;
        s1_prev = ifc.sclk;
      end
      ifc.miso = (s1_fall < 32) ? slave_mem[s1_frame][31 - s1_fall] : 1'b0;
    end
  end

  initial begin
    ifc2.miso = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc2.cs_n) begin
        s2_fall = 0;
        s2_prev = 1'b0;
      end else begin
        if (s2_prev && !ifc2.sclk) s2_fall++;
        s2_prev = ifc2.sclk;
      end
      ifc2.miso = (s2_fall < 32) ? slave2_word[31 - s2_fall] : 1'b0;
    end
  end

  // Monitor for the main DUT
  initial begin
    int low_cnt = 0;
    int rise_cnt = 0;
    bit sclk_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low_cnt = 0;
        rise_cnt = 0;
        sclk_prev = 1'b0;
      end else begin
        if (!ifc.cs_n) begin
          low_cnt++;
          if (ifc.sclk && !sclk_prev) rise_cnt++;
          if (low_cnt == 1) check("busy_in_frame", 64'(ifc.busy), 64'(1));
        end else if (low_cnt != 0) begin
          check("frame_len", 64'(low_cnt), 64'(FRAME_LEN));
          check("sclk_rises", 64'(rise_cnt), 64'(32));
          check("mosi", 64'(ifc.mosi), 64'(0));
          frame_cnt++;
          low_cnt = 0;
          rise_cnt = 0;
        end
        sclk_prev = ifc.sclk;
        if (ifc.wr_en) begin
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected actual addr=%0d required=none", ifc.wr_addr);
          end else begin
            check("wr_addr", 64'(ifc.wr_addr), 64'(exp_addr_q.pop_front()));
            check("wr_data", 64'(ifc.wr_data), 64'(exp_data_q.pop_front()));
          end
          last_wr_addr = int'(ifc.wr_addr);
          ref_cyc = cyc;
        end
        if (ifc.done) begin
          done_cnt++;
          if (exp_gap_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected actual=1 required=0");
          end else begin
            check("done_latency", 64'(cyc - ref_cyc), 64'(exp_gap_q.pop_front()));
            check("writes_before_done", 64'(exp_addr_q.size()), 64'(0));
          end
        end
      end
    end
  end

  // Monitor for the CLK_DIV=2 DUT
  initial begin
    int low2 = 0;
    int rise2 = 0;
    int r2a = 0;
    int r2b = 0;
    bit sclk2_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        low2 = 0;
        rise2 = 0;
        sclk2_prev = 1'b0;
      end else begin
        if (!ifc2.cs_n) begin
          low2++;
          if (ifc2.sclk && !sclk2_prev) begin
            rise2++;
            if (rise2 == 1) r2a = cyc;
            if (rise2 == 2) r2b = cyc;
          end
        end else if (low2 != 0) begin
          check("frame_len2", 64'(low2), 64'(FRAME_LEN2));
          check("sclk_rises2", 64'(rise2), 64'(32));
          check("sclk_period2", 64'(r2b - r2a), 64'(4));
          low2 = 0;
          rise2 = 0;
        end
        sclk2_prev = ifc2.sclk;
        if (ifc2.wr_en) begin
          if (exp2_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr2_unexpected actual=%0h required=none", ifc2.wr_data);
          end else begin
            check("wr_data2", 64'(ifc2.wr_data), 64'(exp2_q.pop_front()));
          end
        end
        if (ifc2.done) done2_cnt++;
      end
    end
  end

  task automatic run_read(input int wc);
    int n;
    n = (wc > MAX_WORDS) ? MAX_WORDS : wc;
    s1_frame = 0;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(16'(i));
      exp_data_q.push_back(slave_mem[i]);
    end
    exp_gap_q.push_back((n == 0) ? 2 : CS_GAP + 2);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.word_count = 16'(wc);
    ref_cyc = cyc;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    ifc.word_count = 16'hFFFF;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(done_cnt > d0), 64'(1));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int d;
    int n;
    bit bsy;
    bit csl;
    ifc.start = 1'b0;
    ifc.word_count = 16'd0;
    ifc2.start = 1'b0;
    ifc2.word_count = 16'd0;
    for (int i = 0; i < 128; i++) slave_mem[i] = 32'd0;

    repeat (3) @(negedge clk);
    check("reset_state", {10'd0, ifc.sclk, ifc.cs_n, ifc.mosi, ifc.busy, ifc.done, ifc.wr_en,
                          ifc.wr_addr, ifc.wr_data}, {10'd0, 6'b010000, 16'd0, 32'd0});
    check("reset_state2", {10'd0, ifc2.sclk, ifc2.cs_n, ifc2.mosi, ifc2.busy, ifc2.done,
                           ifc2.wr_en, ifc2.wr_addr, ifc2.wr_data}, {10'd0, 6'b010000, 16'd0, 32'd0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single word
    slave_mem[0] = 32'hDEADBEEF;
    d = frame_cnt;
    run_read(1);
    wait_done(2000, "done_single");
    check("frames_single", 64'(frame_cnt - d), 64'(1));

    // three words, with an ignored start mid-frame
    slave_mem[0] = 32'h00000001;
    slave_mem[1] = 32'h80000000;
    slave_mem[2] = 32'hA5A5A5A5;
    d = frame_cnt;
    run_read(3);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1;
    ifc.start = 1'b1;
    ifc.word_count = 16'd5;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    wait_done(5000, "done_three");
    check("frames_three", 64'(frame_cnt - d), 64'(3));

    // zero length
    d = done_cnt;
    n = frame_cnt;
    run_read(0);
    bsy = 1'b0;
    csl = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bsy = bsy | ifc.busy;
      csl = csl | !ifc.cs_n;
    end
    check("zero_done", 64'(done_cnt - d), 64'(1));
    check("zero_busy", 64'(bsy), 64'(0));
    check("zero_cs", 64'(csl), 64'(0));
    check("zero_frames", 64'(frame_cnt - n), 64'(0));

    // clamp to MAX_WORDS
    for (int i = 0; i < 128; i++) slave_mem[i] = {16'hC0DE, 16'(i * 7)};
    d = frame_cnt;
    run_read(150);
    wait_done(40000, "done_clamp");
    check("frames_clamp", 64'(frame_cnt - d), 64'(MAX_WORDS));
    check("last_addr_clamp", 64'(last_wr_addr), 64'(MAX_WORDS - 1));

    // reset during bit 15 of the second word
    slave_mem[0] = 32'h11112222;
    slave_mem[1] = 32'h33334444;
    run_read(2);
    n = 0;
    while (!(s1_frame == 1 && s1_fall == 16) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_bit15", 64'(n < 5000), 64'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_cs_n", 64'(ifc.cs_n), 64'(1));
    check("rst_sclk", 64'(ifc.sclk), 64'(0));
    check("rst_busy", 64'(ifc.busy), 64'(0));
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_gap_q.delete();
    repeat (3) @(negedge clk);
    s1_frame = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    slave_mem[0] = 32'hCAFEF00D;
    d = frame_cnt;
    run_read(1);
    wait_done(2000, "done_after_rst");
    check("frames_after_rst", 64'(frame_cnt - d), 64'(1));
    check("addr_after_rst", 64'(last_wr_addr), 64'(0));

    // CLK_DIV=2 instance
    slave2_word = 32'h12345678;
    exp2_q.push_back(32'h12345678);
    d = done2_cnt;
    @(posedge clk);
    #1;
    ifc2.start = 1'b1;
    ifc2.word_count = 16'd1;
    @(posedge clk);
    #1;
    ifc2.start = 1'b0;
    n = 0;
    while (done2_cnt == d && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_div2", 64'(done2_cnt - d), 64'(1));

    repeat (3) @(negedge clk);
    check("queues_empty", 64'(exp_addr_q.size() + exp2_q.size() + exp_gap_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
